// File: rtl/parse_pkg.sv
// -----------------------------------------------------------------------------
// parse_pkg
// Shared definitions for the fetch bundle parser.
//   - BUNDLE_W / SLOT_W     : bundle and instruction slot widths
//   - *_BIT / *_MSB / *_LSB : field positions inside a 30-bit slot
//   - INVALID_BUNDLE        : all-ones pattern Fetch drives while in reset
//   - instr_t               : decoded instruction fields
//   - decode_slot()         : splits one slot into instr_t
// -----------------------------------------------------------------------------
package parse_pkg;

    localparam int BUNDLE_W = 60;
    localparam int SLOT_W   = 30;

    // Slot field layout
    localparam int FORMAT_BIT  = 29;
    localparam int BRANCH_BIT  = 28;
    localparam int OPCODE_MSB  = 27;
    localparam int OPCODE_LSB  = 21;
    localparam int PRIM_MSB    = 20;
    localparam int PRIM_LSB    = 16;
    localparam int SEC_MSB     = 15;
    localparam int SEC_LSB     = 11;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 0;

    localparam logic [BUNDLE_W-1:0] INVALID_BUNDLE = '1;

    typedef struct packed {
        logic        format;    // 1 = reg-imm, 0 = reg-reg
        logic        branch;
        logic [6:0]  opcode;
        logic [4:0]  prim_reg;
        logic [4:0]  sec_reg;   // meaningful for reg-reg
        logic [15:0] imm;       // meaningful for reg-imm
    } instr_t;

    // secReg and imm overlap in the slot; both are always extracted and
    // decode picks one by format.
    function automatic instr_t decode_slot(input logic [SLOT_W-1:0] s);
        instr_t d;
        d.format   = s[FORMAT_BIT];
        d.branch   = s[BRANCH_BIT];
        d.opcode   = s[OPCODE_MSB:OPCODE_LSB];
        d.prim_reg = s[PRIM_MSB:PRIM_LSB];
        d.sec_reg  = s[SEC_MSB:SEC_LSB];
        d.imm      = s[IMM_MSB:IMM_LSB];
        return d;
    endfunction

endpackage

// File: rtl/fetch_parse_fifo.sv
// -----------------------------------------------------------------------------
// fetch_parse_fifo
// Synchronous FIFO for fetch bundles with asynchronous reset and flush.
// The head entry is read combinationally so the parser can issue in the
// cycle after a bundle is written.
// Ports:
//   clock_i, reset_i : clock, async active-high reset
//   flush            : clears pointers and occupancy (wins over push/pop)
//   push, wr_data    : write request; accepted when not full, or when full
//                      and a pop happens in the same cycle
//   pop              : remove the head entry (ignored when empty)
//   rd_data          : head entry
//   full, empty      : occupancy flags
//   count_next       : occupancy after this edge
// -----------------------------------------------------------------------------
module fetch_parse_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 60
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic accept;
    logic pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a bundle when the head leaves in the same cycle.
    assign accept  = push && (!full || pop_ok);
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({accept, pop_ok})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clock_i) begin
        if (accept && !flush) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/fetch_parse.sv
// -----------------------------------------------------------------------------
// fetch_parse
// Consumer end of the fetch bundle interface. Buffers 60-bit two-instruction
// bundles, splits them into 30-bit slots (upper slot first) and issues one
// decoded instruction per cycle over a valid/ready handshake.
// Parameters:
//   DEPTH        : bundle FIFO depth, power of two, >= 2
//   STALL_MARGIN : stall_o asserts when occupancy >= DEPTH-STALL_MARGIN
// Ports:
//   clock_i, reset_i       : clock, async active-high reset
//   flushBack_i            : synchronous flush (overflow_o survives it)
//   data_i, enable_i       : incoming bundle and its qualifier
//   stall_o                : registered almost-full
//   overflow_o             : sticky, a bundle was dropped while full
//   instr_valid_o/ready_i  : output handshake
//   instr_*_o              : decoded fields of the issued slot
//   instr_slot_o           : 0 = upper half, 1 = lower half
// Build option:
//   FETCH_PARSE_NOP_SQUASH_EN : when defined, all-zero slots are skipped
//                               instead of issued.
// -----------------------------------------------------------------------------
module fetch_parse
    import parse_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 1
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                flushBack_i,
    input  logic [BUNDLE_W-1:0] data_i,
    input  logic                enable_i,
    output logic                stall_o,
    output logic                overflow_o,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic                instr_format_o,
    output logic                instr_branch_o,
    output logic [6:0]          instr_opcode_o,
    output logic [4:0]          instr_primReg_o,
    output logic [4:0]          instr_secReg_o,
    output logic [15:0]         instr_imm_o,
    output logic                instr_slot_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [BUNDLE_W-1:0] head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       count_next;

    logic                push_req;
    logic                pop_req;
    logic                drop;

    logic [SLOT_W-1:0]   slot_data [2];
    logic [SLOT_W-1:0]   cur_slot;
    logic                slot_is_nop;
    logic                out_free;
    logic                take;
    logic                load;

    logic                slot_ptr_reg;
    logic                valid_reg;
    logic                slot_reg;
    logic                stall_reg;
    logic                overflow_reg;
    instr_t              instr_reg;

    // Fetch drives all-ones while it is in reset; such bundles carry nothing.
    assign push_req = enable_i && (data_i != INVALID_BUNDLE) && !flushBack_i;
    assign drop     = push_req && fifo_full && !pop_req;

    fetch_parse_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BUNDLE_W)
    ) u_fifo (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .flush      (flushBack_i),
        .push       (push_req),
        .wr_data    (data_i),
        .pop        (pop_req),
        .rd_data    (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count_next (count_next)
    );

    // Slot 0 occupies the upper half of the bundle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_data[gi] = head[BUNDLE_W-1-gi*SLOT_W -: SLOT_W];
        end
    endgenerate

    assign cur_slot = slot_data[slot_ptr_reg];

`ifdef FETCH_PARSE_NOP_SQUASH_EN
    assign slot_is_nop = (cur_slot == '0);
`else
    assign slot_is_nop = 1'b0;
`endif

    // The output register can accept a new slot when it is empty or being
    // consumed. A squashed slot still advances the pointer but loads nothing.
    assign out_free = !valid_reg || instr_ready_i;
    assign take     = out_free && !fifo_empty && !flushBack_i;
    assign load     = take && !slot_is_nop;
    assign pop_req  = take && slot_ptr_reg;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            slot_ptr_reg <= 1'b0;
            valid_reg    <= 1'b0;
            slot_reg     <= 1'b0;
            instr_reg    <= '0;
        end else if (flushBack_i) begin
            slot_ptr_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            if (take) slot_ptr_reg <= ~slot_ptr_reg;
            if (out_free) begin
                valid_reg <= load;
                if (load) begin
                    instr_reg <= decode_slot(cur_slot);
                    slot_reg  <= slot_ptr_reg;
                end
            end
        end
    end

    // stall follows next-cycle occupancy so it is registered but not late.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stall_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            stall_reg <= (count_next >= CW'(DEPTH - STALL_MARGIN));
            if (drop) overflow_reg <= 1'b1;
        end
    end

    assign stall_o         = stall_reg;
    assign overflow_o      = overflow_reg;
    assign instr_valid_o   = valid_reg;
    assign instr_slot_o    = slot_reg;
    assign instr_format_o  = instr_reg.format;
    assign instr_branch_o  = instr_reg.branch;
    assign instr_opcode_o  = instr_reg.opcode;
    assign instr_primReg_o = instr_reg.prim_reg;
    assign instr_secReg_o  = instr_reg.sec_reg;
    assign instr_imm_o     = instr_reg.imm;

endmodule
